mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: data-memory read latency in clk cycles, legal range 1..4.
REQ-002 SHALL have ports `clk` (input, 1) as the sole clock; all state updates on posedge `clk`.
REQ-003 SHALL have port `rst` (input, 1), reset that is asynchronous and active-high.
REQ-004 SHALL have ports `cpu_req` (input, 1) for CPU access request and `cpu_ldst` (input, `LDST_WID`) for the load/store op code (LW/LH/LHU/LB/LBU/SW/SH/SB).
REQ-005 SHALL have ports `cpu_addr` (input, 32) for the byte address and `cpu_wdata` (input, 32) for store data (low bits used for SB/SH).
REQ-006 SHALL have ports `cpu_rdata` (output, 32) for extended load result, `cpu_done` (output, 1) for the completion pulse, and `cpu_stall` (output, 1) for the pipeline hold.
REQ-007 SHALL have ports `uart_req` (input, 1) for the loader word-write request, `uart_addr` (input, 32), `uart_wdata` (input, 32) and `uart_ack` (output, 1) for the one-cycle write-accepted pulse.
REQ-008 SHALL have ports `mem_addr` (output, 32) for the word-aligned address and `mem_wdata` (output, 32), `mem_we` (output, 1) and `mem_rdata` (input, 32) towards the single-port data RAM.

Function
REQ-009 SHALL implement states IDLE, READ, WRITE, DONE; exactly one access in flight.
REQ-010 SHALL, in IDLE, grant UART over CPU when both request in the same cycle (fixed priority); a loser stays pending, no request dropped.
REQ-011 Transitions SHALL be:
- LW/LH/LHU/LB/LBU: IDLE->READ->DONE->IDLE.
- SW: IDLE->WRITE->DONE->IDLE.
- SB/SH: IDLE->READ->WRITE->DONE->IDLE.
- UART: IDLE->WRITE->IDLE.
REQ-012 SHALL hold READ for exactly RD_LAT cycles (internal counter) and sample `mem_rdata` on the last READ cycle.
REQ-013 SHALL drive `mem_addr` = {addr[31:2],2'b00} of the granted requester, latched at grant and stable until return to IDLE.
REQ-014 SHALL assert `mem_we` for exactly one cycle, in WRITE only.
REQ-015 Write data in WRITE SHALL be:
- SW: `cpu_wdata`.
- SH: read word with halfword addr[1] replaced by wdata[15:0].
- SB: read word with byte addr[1:0] replaced by wdata[7:0].
- UART: `uart_wdata`.
REQ-016 Load results SHALL be:
- LW: word.
- LH/LB: sign-extended halfword/byte selected by addr[1:0].
- LHU/LBU: zero-extended.
REQ-017 SHALL register `cpu_rdata` in DONE and hold it until the next CPU DONE.
REQ-018 SHALL pulse `cpu_done` for one cycle in DONE.
REQ-019 SHALL drive `cpu_stall` = `cpu_req` & ~`cpu_done` (combinational).
REQ-020 SHALL pulse `uart_ack` in the UART WRITE cycle.
REQ-021 SHALL ignore misaligned LW/LH/SH low bits (word/halfword select only); no fault generation.
REQ-022 SHALL ignore request and input changes after grant until IDLE.

Reset
REQ-023 On `rst` assertion, SHALL asynchronously force state IDLE, RD counter 0, and `mem_we`, `cpu_done`, `uart_ack` to 0, `cpu_rdata` to 0, and `mem_addr`/`mem_wdata` to 0; an in-flight RMW SHALL be abandoned with no write issued.

Configuration
REQ-024 With macro UART_LOADER_EN defined, SHALL include UART arbitration per REQ-010/REQ-020.
REQ-025 Without UART_LOADER_EN, SHALL ignore the uart_* inputs, tie `uart_ack` to 0, and serve the CPU only.

Verification
REQ-026 Bench SHALL check: RD_LAT=1, mem word 0x80FF7F01, LB addr 0x103 -> `cpu_done` on cycle 3 after request, `cpu_rdata`=0xFFFFFF80.
REQ-027 Bench SHALL check: SB addr 0x102, wdata 0xAB, mem 0x11223344 -> one `mem_we` cycle at addr 0x100, `mem_wdata`=0x11AB3344.
REQ-028 Bench SHALL check: SH addr 0x202, wdata 0xBEEF, RD_LAT=3 -> READ lasts 3 cycles, write 0xBEEFxxxx (low half preserved).
REQ-029 Bench SHALL check: `uart_req` and `cpu_req` (LW) in the same cycle with UART_LOADER_EN -> `uart_ack` first, then CPU READ, `cpu_stall` high throughout until `cpu_done`.
REQ-030 Bench SHALL check: `rst` pulsed during SB READ -> `mem_we` never asserted, state IDLE; re-request completes normally.
REQ-031 Bench SHALL check: without UART_LOADER_EN, `uart_req`=1 continuously -> `uart_ack`=0, CPU SW completes in 2 cycles.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port data-RAM access controller.
//
// Serves CPU loads/stores (LW/LH/LHU/LB/LBU/SW/SH/SB) and, optionally, word
// writes from a UART loader. One access is in flight at a time. Sub-word
// stores run as read-modify-write. Loads are extended and registered into
// cpu_rdata.
//
// Optional feature macro: UART_LOADER_EN. When defined, the UART loader takes
// fixed priority over the CPU. When undefined, uart_* inputs are ignored and
// uart_ack is tied low.
//
// Parameters
//   RD_LAT     data-RAM read latency in cycles (1..4)
//   LDST_WID   width of the cpu_ldst op code (fixed encoding, see Op* below)
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   cpu_req/ldst/addr/wdata CPU request, op code, byte address, store data
//   cpu_rdata/done/stall   extended load result, completion pulse, hold
//   uart_req/addr/wdata    loader word-write request
//   uart_ack               one-cycle write-accepted pulse
//   mem_addr/wdata/we      word-aligned RAM address, write data, write enable
//   mem_rdata              RAM read data
module mem_access_ctrl #(
    parameter int RD_LAT = 1,
    localparam int LDST_WID = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic [LDST_WID-1:0] cpu_ldst,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_done,
    output logic                cpu_stall,
    input  logic                uart_req,
    input  logic [31:0]         uart_addr,
    input  logic [31:0]         uart_wdata,
    output logic                uart_ack,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_we,
    input  logic [31:0]         mem_rdata
);

    localparam logic [LDST_WID-1:0] OpLw  = 3'd0;
    localparam logic [LDST_WID-1:0] OpLh  = 3'd1;
    localparam logic [LDST_WID-1:0] OpLhu = 3'd2;
    localparam logic [LDST_WID-1:0] OpLb  = 3'd3;
    localparam logic [LDST_WID-1:0] OpLbu = 3'd4;
    localparam logic [LDST_WID-1:0] OpSw  = 3'd5;
    localparam logic [LDST_WID-1:0] OpSh  = 3'd6;
    localparam logic [LDST_WID-1:0] OpSb  = 3'd7;

    localparam logic [1:0] LastCnt = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e              r_state;
    state_e              w_next_state;
    logic [1:0]          r_cnt;
    logic [31:0]         r_addr;
    logic [LDST_WID-1:0] r_op;
    logic                r_is_uart;
    logic [31:0]         r_wdata;
    logic [31:0]         r_cpu_rdata;

    logic                w_grant_uart;
    logic                w_rd_last;
    logic                w_rmw;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [31:0]         w_merge;

`ifdef UART_LOADER_EN
    assign w_grant_uart = uart_req;
`else
    logic w_unused_uart;
    assign w_unused_uart = uart_req;
    assign w_grant_uart  = 1'b0;
`endif

    assign w_rd_last = (r_state == StRead) && (r_cnt == LastCnt);
    assign w_rmw     = (r_op == OpSb) || (r_op == OpSh);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle: begin
                if (w_grant_uart) begin
                    w_next_state = StWrite;
                end else if (cpu_req) begin
                    // Loads and sub-word stores both need the current word first.
                    w_next_state = (cpu_ldst == OpSw) ? StWrite : StRead;
                end
            end
            StRead: begin
                if (w_rd_last) begin
                    w_next_state = w_rmw ? StWrite : StDone;
                end
            end
            StWrite: w_next_state = r_is_uart ? StIdle : StDone;
            StDone:  w_next_state = StIdle;
            default: w_next_state = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        mem_we    = (r_state == StWrite);
        cpu_done  = (r_state == StDone);
        cpu_stall = cpu_req & ~cpu_done;
`ifdef UART_LOADER_EN
        uart_ack  = (r_state == StWrite) & r_is_uart;
`else
        uart_ack  = 1'b0;
`endif
    end

    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;

    // Lane select and extension of the word returned by the RAM
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_op)
            OpLb:    w_load = {{24{w_byte[7]}}, w_byte};
            OpLbu:   w_load = {24'd0, w_byte};
            OpLh:    w_load = {{16{w_half[15]}}, w_half};
            OpLhu:   w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Sub-word store merge: r_wdata still holds the CPU store data here
    always_comb begin
        w_merge = mem_rdata;
        if (r_op == OpSb) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    // Request latching, read-latency counter, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 2'd0;
            r_addr      <= 32'd0;
            r_op        <= OpLw;
            r_is_uart   <= 1'b0;
            r_wdata     <= 32'd0;
            r_cpu_rdata <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_grant_uart || cpu_req) begin
                        r_cnt     <= 2'd0;
                        r_is_uart <= w_grant_uart;
                        if (w_grant_uart) begin
                            r_addr  <= uart_addr;
                            r_wdata <= uart_wdata;
                            r_op    <= OpSw;
                        end else begin
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                            r_op    <= cpu_ldst;
                        end
                    end
                end
                StRead: begin
                    if (w_rd_last) begin
                        r_cnt <= 2'd0;
                        if (w_rmw) begin
                            r_wdata <= w_merge;
                        end else begin
                            r_cpu_rdata <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
